// File: rtl/hello_scroller_if.sv
// Control and display bundle for the HELLO message scroller.
// master: start/stop/pause/dir in, q5..q0/wrap/running out. slave: the reverse.
interface hello_scroller_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic       dir;
    logic [3:0] q5;
    logic [3:0] q4;
    logic [3:0] q3;
    logic [3:0] q2;
    logic [3:0] q1;
    logic [3:0] q0;
    logic       wrap;
    logic       running;

    modport master (
        output start, stop, pause, dir,
        input  q5, q4, q3, q2, q1, q0, wrap, running
    );

    modport slave (
        input  start, stop, pause, dir,
        output q5, q4, q3, q2, q1, q0, wrap, running
    );
endinterface

// File: rtl/hello_scroller.sv
// Scrolls the 9-entry ring "HELLO____" across six HEX digits.
// Ports: clk, reset (async, active-high), bus (slave): start/stop/pause/dir in,
// q5..q0 symbol codes, wrap pulse and running flag out.
module hello_scroller #(
    parameter int unsigned DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    hello_scroller_if.slave  bus
);

    localparam logic [24:0] CNT_MAX = 25'(DIV - 1);

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SCROLL = 2'd1,
        FREEZE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pos_q, pos_d;
    logic [24:0] cnt_q, cnt_d;
    logic        wrap_q, wrap_d;
    logic        tick;
    logic        running;

    // Ring code shown on digit n: ((pos + 5 - n) mod 9) + 1.
    function automatic logic [3:0] digit(input logic [3:0] p, input logic [2:0] n);
        logic [4:0] s;
        s = {1'b0, p} + 5'd5 - {2'b00, n};
        if (s >= 5'd9) s = s - 5'd9;
        return s[3:0] + 4'd1;
    endfunction

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (bus.start && !bus.stop) begin
                    state_d = SCROLL;
                    pos_d   = 4'd0;
                    cnt_d   = '0;
                end
            end
            SCROLL: begin
                if (bus.stop) begin
                    state_d = BLANK;
                    pos_d   = 4'd0;
                    cnt_d   = '0;
                end else if (bus.pause) begin
                    // Pause beats tick: cnt stays at its current value.
                    state_d = FREEZE;
                end else if (tick) begin
                    cnt_d = '0;
                    if (bus.dir) begin
                        pos_d  = (pos_q == 4'd0) ? 4'd8 : pos_q - 4'd1;
                        wrap_d = (pos_q == 4'd0);
                    end else begin
                        pos_d  = (pos_q == 4'd8) ? 4'd0 : pos_q + 4'd1;
                        wrap_d = (pos_q == 4'd8);
                    end
                end else begin
                    cnt_d = cnt_q + 25'd1;
                end
            end
            FREEZE: begin
                if (bus.stop) begin
                    state_d = BLANK;
                    pos_d   = 4'd0;
                    cnt_d   = '0;
                end else if (!bus.pause) begin
                    state_d = SCROLL;
                end
            end
            default: begin
                state_d = BLANK;
                pos_d   = 4'd0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            pos_q   <= 4'd0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign running     = (state_q != BLANK);
    assign bus.running = running;
    assign bus.wrap    = wrap_q;
    assign bus.q5      = running ? digit(pos_q, 3'd5) : 4'd0;
    assign bus.q4      = running ? digit(pos_q, 3'd4) : 4'd0;
    assign bus.q3      = running ? digit(pos_q, 3'd3) : 4'd0;
    assign bus.q2      = running ? digit(pos_q, 3'd2) : 4'd0;
    assign bus.q1      = running ? digit(pos_q, 3'd1) : 4'd0;
    assign bus.q0      = running ? digit(pos_q, 3'd0) : 4'd0;

endmodule
